// File: rtl/channel_phase_counter.sv
// Per-channel tone oscillator core.
// Divides the sample-rate tick (ena) by a note divider and produces a free-running
// M-bit phase ramp for the channel's wave generators. Note changes are double-buffered
// and only take effect when the phase wraps, so waveforms never glitch mid-cycle.
module channel_phase_counter #(
  parameter int M = 6,   // phase (period) output width
  parameter int D = 16   // note divider width
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         note_valid,
  input  logic [D-1:0] note_div,
  output logic         note_ready,
  output logic [M-1:0] period,
  output logic         wrap,
  output logic         active
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state, state_nxt;
  logic [M-1:0] period_nxt;
  logic         wrap_nxt;
  logic [D-1:0] div_cnt, div_cnt_nxt;
  logic [D-1:0] div_reg, div_reg_nxt;
  logic         pend_valid, pend_valid_nxt;
  logic [D-1:0] pend_div, pend_div_nxt;

  logic         accept;
  logic         div_last;
  logic         phase_top;

  // Handshake and step qualifiers derived from current state.
  assign accept     = note_valid & note_ready;
  assign div_last   = (div_cnt == div_reg - D'(1));
  assign phase_top  = &period;

  // Ready is a pure function of registered state: always open in IDLE, and in RUN
  // only while the single-entry pending buffer is empty.
  assign note_ready = (state == IDLE) | ~pend_valid;
  assign active     = (state == RUN);

  // Next-state and datapath logic for the oscillator.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no path
    // can leave one unassigned and infer a latch.
    state_nxt      = state;
    period_nxt     = period;
    wrap_nxt       = 1'b0;
    div_cnt_nxt    = div_cnt;
    div_reg_nxt    = div_reg;
    pend_valid_nxt = pend_valid;
    pend_div_nxt   = pend_div;

    unique case (state)
      IDLE: begin
        // Phase held at zero and counters frozen until a real note arrives.
        period_nxt  = '0;
        div_cnt_nxt = '0;
        if (accept && (note_div != '0)) begin
          state_nxt   = RUN;
          div_reg_nxt = note_div;
        end
      end

      RUN: begin
        if (ena) begin
          if (div_last) begin
            div_cnt_nxt = '0;
            period_nxt  = period + M'(1);
            if (phase_top) begin
              // Phase returns to zero: the only point where a buffered note may apply.
              wrap_nxt = 1'b1;
              if (pend_valid) begin
                pend_valid_nxt = 1'b0;
                if (pend_div == '0) begin
                  state_nxt  = IDLE;
                  period_nxt = '0;
                end else begin
                  div_reg_nxt = pend_div;
                end
              end
            end
          end else begin
            div_cnt_nxt = div_cnt + D'(1);
          end
        end
        // A note accepted here (buffer empty, so never on top of one being applied)
        // waits for the following wrap, even if a wrap happens on this same edge.
        if (accept) begin
          pend_valid_nxt = 1'b1;
          pend_div_nxt   = note_div;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset aborts any run and discards a pending note.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the values from before the edge, independent of statement order.
    if (rst) begin
      state      <= IDLE;
      period     <= '0;
      wrap       <= 1'b0;
      div_cnt    <= '0;
      div_reg    <= '0;
      pend_valid <= 1'b0;
      // NOTE: the buffered divider is reset too, so the data path never carries X
      // values even though pend_valid alone gates its use.
      pend_div   <= '0;
    end else begin
      state      <= state_nxt;
      period     <= period_nxt;
      wrap       <= wrap_nxt;
      div_cnt    <= div_cnt_nxt;
      div_reg    <= div_reg_nxt;
      pend_valid <= pend_valid_nxt;
      pend_div   <= pend_div_nxt;
    end
  end

endmodule

// File: tb/tb_channel_phase_counter.sv
// Self-checking bench for channel_phase_counter: directed scenarios plus randomized
// traffic, all compared every cycle against a tick-counting behavioural model.
module tb_channel_phase_counter;

  localparam int M   = 6;
  localparam int D   = 16;
  localparam int TOP = 1 << M;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic         note_valid;
  logic [D-1:0] note_div;
  logic         note_ready;
  logic [M-1:0] period;
  logic         wrap;
  logic         active;

  int n_cmp = 0;
  int n_err = 0;

  channel_phase_counter #(.M(M), .D(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .note_valid (note_valid),
    .note_div   (note_div),
    .note_ready (note_ready),
    .period     (period),
    .wrap       (wrap),
    .active     (active)
  );

  always #5 clk = ~clk;

  // Behavioural model: the phase is the number of ena ticks since the last wrap (or
  // since the note started) divided by the note divider.
  bit m_run;
  int m_div;
  int m_ticks;
  bit m_pend;
  int m_pdiv;
  bit m_wrap;

  function automatic int m_period();
    return m_run ? (m_ticks / m_div) : 0;
  endfunction

  function automatic bit m_ready();
    return !m_run || !m_pend;
  endfunction

  task automatic model_reset();
    m_run   = 1'b0;
    m_div   = 0;
    m_ticks = 0;
    m_pend  = 1'b0;
    m_pdiv  = 0;
    m_wrap  = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit v, input int d);
    bit acc;
    acc    = v && m_ready();
    m_wrap = 1'b0;
    if (!m_run) begin
      if (acc && d != 0) begin
        m_run   = 1'b1;
        m_div   = d;
        m_ticks = 0;
      end
    end else begin
      if (e) begin
        m_ticks++;
        if (m_ticks == m_div * TOP) begin
          m_ticks = 0;
          m_wrap  = 1'b1;
          if (m_pend) begin
            m_pend = 1'b0;
            if (m_pdiv != 0) m_div = m_pdiv;
            else m_run = 1'b0;
          end
        end
      end
      if (acc) begin
        m_pend = 1'b1;
        m_pdiv = d;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("period",     32'(period),     32'(m_period()));
    check("wrap",       32'(wrap),       32'(m_wrap));
    check("active",     32'(active),     32'(m_run));
    check("note_ready", 32'(note_ready), 32'(m_ready()));
  endtask

  // One clock cycle: drive at the falling edge, let the rising edge act, compare at
  // the next falling edge.
  task automatic tick(input bit e, input bit v, input int d);
    ena        = e;
    note_valid = v;
    note_div   = d[D-1:0];
    model_step(e, v, d);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset asserted between edges; outputs must respond without a clock.
  task automatic async_reset(input string tag);
    ena        = 1'b0;
    note_valid = 1'b0;
    note_div   = '0;
    #2 rst = 1'b1;
    #1;
    check({tag, "_rst_period"}, 32'(period),     32'd0);
    check({tag, "_rst_wrap"},   32'(wrap),       32'd0);
    check({tag, "_rst_active"}, 32'(active),     32'd0);
    check({tag, "_rst_ready"},  32'(note_ready), 32'd1);
    model_reset();
    @(negedge clk);
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int k;
    bit seen;
    int p_before;
    bit hv;
    int hd;
    bit acc;
    bit e;

    // Reset with no clock edge yet.
    rst        = 1'b1;
    ena        = 1'b0;
    note_valid = 1'b0;
    note_div   = '0;
    #1;
    check("init_period", 32'(period),     32'd0);
    check("init_wrap",   32'(wrap),       32'd0);
    check("init_active", 32'(active),     32'd0);
    check("init_ready",  32'(note_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    compare_all();

    // Run at div=3: period steps every 3 ticks, wrap after 192 ticks.
    tick(1'b1, 1'b1, 3);
    check("t2_active_entry", 32'(active), 32'd1);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      tick(1'b1, 1'b0, 0);
      n++;
      if (n == 3) check("t2_first_step", 32'(period), 32'd1);
      if (wrap === 1'b1) break;
    end
    check("t2_wrap_ticks",   32'(n),      32'd192);
    check("t2_wrap_period",  32'(period), 32'd0);
    check("t2_wrap_active",  32'(active), 32'd1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 0);

    // Note off while running: keeps going to the wrap, then stops.
    tick(1'b1, 1'b1, 0);
    check("t4_ready_drop", 32'(note_ready), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick(1'b1, 1'b0, 0);
      if (wrap === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("t4_wrap_seen", 32'(seen),   32'd1);
    check("t4_off_active", 32'(active), 32'd0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 0);
    check("t4_idle_period", 32'(period), 32'd0);
    // div=0 in IDLE is consumed and changes nothing.
    tick(1'b1, 1'b1, 0);
    tick(1'b1, 1'b0, 0);
    check("t4_idle_zero_active", 32'(active),     32'd0);
    check("t4_idle_zero_ready",  32'(note_ready), 32'd1);

    // Retune from div=2 to div=5 at period 10.
    tick(1'b1, 1'b1, 2);
    for (int i = 0; i < 200 && m_period() != 10; i++) tick(1'b1, 1'b0, 0);
    check("t3_at_ten", 32'(period), 32'd10);
    tick(1'b1, 1'b1, 5);
    check("t3_ready_drop", 32'(note_ready), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick(1'b1, 1'b0, 0);
      if (wrap === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("t3_wrap_seen",   32'(seen),       32'd1);
    check("t3_ready_back",  32'(note_ready), 32'd1);
    k = 0;
    for (int i = 0; i < 20 && period !== M'(1); i++) begin
      tick(1'b1, 1'b0, 0);
      k++;
    end
    check("t3_new_step_ticks", 32'(k), 32'd5);

    // Async reset with a note pending: the pending note must never take effect.
    tick(1'b1, 1'b1, 3);
    check("t6_pending", 32'(note_ready), 32'd0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 0);
    async_reset("t6");
    for (int i = 0; i < 400; i++) tick(1'b1, 1'b0, 0);
    check("t6_after_active", 32'(active), 32'd0);
    check("t6_after_period", 32'(period), 32'd0);

    // Gating with div=1: the phase only moves on ena ticks.
    tick(1'b0, 1'b1, 1);
    for (int i = 0; i < 20; i++) begin
      p_before = int'(period);
      tick(i[0], 1'b0, 0);
      if (!i[0]) check("t5_hold_on_ena0", 32'(period), 32'(p_before));
    end
    for (int i = 0; i < 200 && m_period() != 63; i++) tick(1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 0);
    check("t5_top_held",   32'(period), 32'd63);
    check("t5_no_wrap",    32'(wrap),   32'd0);
    tick(1'b1, 1'b0, 0);
    check("t5_wrap_late",  32'(wrap),   32'd1);
    check("t5_wrap_zero",  32'(period), 32'd0);

    // Randomized traffic: the source holds a note until it is accepted.
    hv = 1'b0;
    hd = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 1000 == 0) begin
        async_reset("rnd");
        hv = 1'b0;
      end
      e = ($urandom % 4) != 0;
      if (!hv && ($urandom % 16) == 0) begin
        hv = 1'b1;
        hd = $urandom_range(0, 3);
      end
      acc = hv && m_ready();
      tick(e, hv, hd);
      if (acc) hv = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
